// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store sequencer for a 32-bit word-addressed data RAM
//
// Purpose:
//   Takes one load/store request at a time from the core, drives the RAM
//   request/ack handshake, builds byte enables and lane-replicated store data,
//   aligns and sign/zero-extends load data, and reports misaligned, illegal
//   and timed-out accesses as a faulted response.
//   Optional feature macro: MISALIGNED_SPLIT_EN. When defined, misaligned
//   accesses are serviced instead of faulted; word-crossing ones take two beats.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   req_valid/req_ready           core request handshake
//   req_we, req_size              1=store / funct3 size code
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid                    one-cycle completion pulse
//   resp_rdata, resp_fault        extended load data, fault flag
//   mem_req/mem_ack               RAM handshake (mem_req held until mem_ack)
//   mem_we, mem_addr, mem_be      RAM write, word address, byte enables
//   mem_wdata, mem_rdata          RAM write data, RAM read data
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // The timeout fires on the cycle the counter would reach TIMEOUT, so
  // mem_req is high for exactly TIMEOUT cycles when no ack arrives.
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
    S_ACCESS2 = 2'd2,
`endif
    S_RESP    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       size_q;
  logic [1:0]       off_q;

`ifdef MISALIGNED_SPLIT_EN
  logic             split_q;
  logic [3:0]       be2_q;
  logic [31:0]      wdata2_q;
  logic [31:0]      beat1_q;
`endif

  // Request decode, evaluated on the accept cycle
  logic [1:0]  in_off;
  logic        size_bad;
  logic        misaligned;
  logic        reject;
  logic [3:0]  mask4;
  logic [31:0] wsz;
  logic [31:0] wrep;
  logic        timeout_hit;

  assign in_off      = req_addr[1:0];
  assign timeout_hit = TO_EN && (cnt == CNT_LAST);

  always_comb begin
    size_bad   = (req_size == 3'b011) || (req_size[2:1] == 2'b11) ||
                 (req_size[2] && req_we);
    misaligned = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_size[1:0] == 2'b10) && (in_off != 2'b00));
    case (req_size[1:0])
      2'b00: begin
        mask4 = 4'b0001;
        wsz   = {24'h0, req_wdata[7:0]};
        wrep  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mask4 = 4'b0011;
        wsz   = {16'h0, req_wdata[15:0]};
        wrep  = {2{req_wdata[15:0]}};
      end
      default: begin
        mask4 = 4'b1111;
        wsz   = req_wdata;
        wrep  = req_wdata;
      end
    endcase
  end

`ifdef MISALIGNED_SPLIT_EN
  // Enables and data laid out across two consecutive words; the upper half
  // belongs to the second beat and is non-zero only for word-crossing access.
  logic [7:0]  be8;
  logic [63:0] wsh;
  assign be8    = {4'b0000, mask4} << in_off;
  assign wsh    = {32'h0, wsz} << {in_off, 3'b000};
  assign reject = size_bad;
`else
  assign reject = size_bad || misaligned;
`endif

  // Align the addressed bytes down to bit 0 and extend per size code.
  // pair is {second word, first word}; single-beat loads pass zero on top.
  function automatic logic [31:0] load_ext(input logic [63:0] pair,
                                           input logic [1:0]  off,
                                           input logic [2:0]  size);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (size)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b101:  load_ext = {16'h0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      size_q     <= 3'b000;
      off_q      <= 2'b00;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
`ifdef MISALIGNED_SPLIT_EN
      split_q    <= 1'b0;
      be2_q      <= 4'h0;
      wdata2_q   <= 32'h0;
      beat1_q    <= 32'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            off_q     <= in_off;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (reject) begin
              // No RAM access; answer with a fault on the next cycle
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state    <= S_ACCESS;
              mem_req  <= 1'b1;
              mem_we   <= req_we;
              mem_addr <= {req_addr[31:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
              mem_be    <= be8[3:0];
              mem_wdata <= misaligned ? wsh[31:0] : wrep;
              split_q   <= |be8[7:4];
              be2_q     <= be8[7:4];
              wdata2_q  <= wsh[63:32];
`else
              mem_be    <= mask4 << in_off;
              mem_wdata <= wrep;
`endif
            end
          end
        end

        S_ACCESS: begin
          if (mem_ack) begin
            cnt <= '0;
`ifdef MISALIGNED_SPLIT_EN
            if (split_q) begin
              // First beat done; keep mem_req up and move to the next word
              beat1_q   <= mem_rdata;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= be2_q;
              mem_wdata <= wdata2_q;
              state     <= S_ACCESS2;
            end else
`endif
            begin
              mem_req    <= 1'b0;
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_rdata <= we_q ? 32'h0 : load_ext({32'h0, mem_rdata}, off_q, size_q);
            end
          end else if (timeout_hit) begin
            mem_req    <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef MISALIGNED_SPLIT_EN
        S_ACCESS2: begin
          if (mem_ack) begin
            cnt        <= '0;
            mem_req    <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= we_q ? 32'h0 : load_ext({mem_rdata, beat1_q}, off_q, size_q);
          end else if (timeout_hit) begin
            mem_req    <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        S_RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          mem_req   <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  // Called at a negedge with req_ready=1; returns at the negedge after accept.
  task automatic issue(input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0) begin n_bad++; $display("FAIL rst resp: got %b%b want 00", resp_valid, resp_fault); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst rdata: got %h want 0", resp_rdata); end
    n_cmp++; if ({mem_req, mem_we, mem_be} !== 6'h0) begin n_bad++; $display("FAIL rst mem ctl: got %b%b%b want 0", mem_req, mem_we, mem_be); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst mem data: got %h %h want 0 0", mem_addr, mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic test_loads;
    ld_vec_t lv [7];
    lv[0] = '{3'b000, 32'h0000_0103, 32'h80AA_BBCC, 4'b1000, 32'hFFFF_FF80};
    lv[1] = '{3'b100, 32'h0000_0103, 32'h80AA_BBCC, 4'b1000, 32'h0000_0080};
    lv[2] = '{3'b000, 32'h0000_0100, 32'h80AA_BB7F, 4'b0001, 32'h0000_007F};
    lv[3] = '{3'b101, 32'h0000_0102, 32'hBEEF_1234, 4'b1100, 32'h0000_BEEF};
    lv[4] = '{3'b001, 32'h0000_0102, 32'hBEEF_1234, 4'b1100, 32'hFFFF_BEEF};
    lv[5] = '{3'b001, 32'h0000_0100, 32'hBEEF_1234, 4'b0011, 32'h0000_1234};
    lv[6] = '{3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, lv[i].size, lv[i].addr, 32'h0);
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL ld[%0d] req/we: got %b%b want 10", i, mem_req, mem_we); end
      n_cmp++; if (mem_addr !== {lv[i].addr[31:2], 2'b00}) begin n_bad++; $display("FAIL ld[%0d] addr: got %h want %h", i, mem_addr, {lv[i].addr[31:2], 2'b00}); end
      n_cmp++; if (mem_be !== lv[i].be) begin n_bad++; $display("FAIL ld[%0d] be: got %b want %b", i, mem_be, lv[i].be); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ld[%0d] busy ready: got %b want 0", i, req_ready); end
      mem_ack = 1'b1; mem_rdata = lv[i].rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0) begin n_bad++; $display("FAIL ld[%0d] resp: got v%b f%b want v1 f0", i, resp_valid, resp_fault); end
      n_cmp++; if (resp_rdata !== lv[i].exp) begin n_bad++; $display("FAIL ld[%0d] rdata: got %h want %h", i, resp_rdata, lv[i].exp); end
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL ld[%0d] req drop: got %b want 0", i, mem_req); end
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL ld[%0d] idle: got v%b r%b want v0 r1", i, resp_valid, req_ready); end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  sz [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [3:0]  eb [3];
    logic [31:0] ew [3];
    sz[0] = 3'b000; ad[0] = 32'h101; wd[0] = 32'h0000_0012; eb[0] = 4'b0010; ew[0] = 32'h1212_1212;
    sz[1] = 3'b001; ad[1] = 32'h102; wd[1] = 32'hAAAA_5678; eb[1] = 4'b1100; ew[1] = 32'h5678_5678;
    sz[2] = 3'b010; ad[2] = 32'h108; wd[2] = 32'hCAFE_F00D; eb[2] = 4'b1111; ew[2] = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, sz[i], ad[i], wd[i]);
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_bad++; $display("FAIL st[%0d] req/we: got %b%b want 11", i, mem_req, mem_we); end
      n_cmp++; if (mem_be !== eb[i]) begin n_bad++; $display("FAIL st[%0d] be: got %b want %b", i, mem_be, eb[i]); end
      n_cmp++; if (mem_wdata !== ew[i]) begin n_bad++; $display("FAIL st[%0d] wdata: got %h want %h", i, mem_wdata, ew[i]); end
      n_cmp++; if (mem_addr !== {ad[i][31:2], 2'b00}) begin n_bad++; $display("FAIL st[%0d] addr: got %h want %h", i, mem_addr, {ad[i][31:2], 2'b00}); end
      mem_ack = 1'b1; mem_rdata = 32'h5A5A_A5A5;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) begin n_bad++; $display("FAIL st[%0d] resp: got v%b f%b %h want v1 f0 0", i, resp_valid, resp_fault, resp_rdata); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal;
    logic       we [6];
    logic [2:0] sz [6];
    we[0] = 1'b0; sz[0] = 3'b011;
    we[1] = 1'b0; sz[1] = 3'b110;
    we[2] = 1'b0; sz[2] = 3'b111;
    we[3] = 1'b1; sz[3] = 3'b100;
    we[4] = 1'b1; sz[4] = 3'b101;
    we[5] = 1'b1; sz[5] = 3'b011;
    for (int i = 0; i < 6; i++) begin
      issue(we[i], sz[i], 32'h100, 32'hFFFF_FFFF);
      n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1) begin n_bad++; $display("FAIL ill[%0d] resp: got v%b f%b want v1 f1", i, resp_valid, resp_fault); end
      n_cmp++; if (mem_req !== 1'b0 || resp_rdata !== 32'h0) begin n_bad++; $display("FAIL ill[%0d] req/rdata: got %b %h want 0 0", i, mem_req, resp_rdata); end
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL ill[%0d] idle: got r%b v%b want r1 v0", i, req_ready, resp_valid); end
    end
  endtask

  task automatic test_misaligned;
`ifdef MISALIGNED_SPLIT_EN
    issue(1'b0, 3'b010, 32'h101, 32'h0);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1110) begin n_bad++; $display("FAIL split beat1: got %b %h %b want 1 00000100 1110", mem_req, mem_addr, mem_be); end
    mem_ack = 1'b1; mem_rdata = 32'h4433_2211;
    @(negedge clk);
    mem_rdata = 32'h8877_6655;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_be !== 4'b0001) begin n_bad++; $display("FAIL split beat2: got %b %h %b want 1 00000104 0001", mem_req, mem_addr, mem_be); end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 32'h5544_3322) begin n_bad++; $display("FAIL split resp: got v%b f%b %h want v1 f0 55443322", resp_valid, resp_fault, resp_rdata); end
    @(negedge clk);
`else
    logic       we [6];
    logic [2:0] sz [6];
    logic [31:0] ad [6];
    we[0] = 1'b0; sz[0] = 3'b010; ad[0] = 32'h101;
    we[1] = 1'b0; sz[1] = 3'b010; ad[1] = 32'h102;
    we[2] = 1'b0; sz[2] = 3'b001; ad[2] = 32'h101;
    we[3] = 1'b1; sz[3] = 3'b001; ad[3] = 32'h103;
    we[4] = 1'b1; sz[4] = 3'b010; ad[4] = 32'h103;
    we[5] = 1'b0; sz[5] = 3'b101; ad[5] = 32'h103;
    for (int i = 0; i < 6; i++) begin
      issue(we[i], sz[i], ad[i], 32'h0);
      n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1) begin n_bad++; $display("FAIL mis[%0d] resp: got v%b f%b want v1 f1", i, resp_valid, resp_fault); end
      n_cmp++; if (mem_req !== 1'b0 || resp_rdata !== 32'h0) begin n_bad++; $display("FAIL mis[%0d] req/rdata: got %b %h want 0 0", i, mem_req, resp_rdata); end
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL mis[%0d] req after: got %b want 0", i, mem_req); end
    end
`endif
  endtask

  task automatic test_timeout;
    int hi;
    hi = 0;
    issue(1'b0, 3'b010, 32'h200, 32'h0);
    for (int i = 0; i < 10 && mem_req === 1'b1; i++) begin
      hi++;
      @(negedge clk);
    end
    n_cmp++; if (hi !== 4) begin n_bad++; $display("FAIL timeout req cycles: got %0d want 4", hi); end
    n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1) begin n_bad++; $display("FAIL timeout resp: got v%b f%b want v1 f1", resp_valid, resp_fault); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL timeout rdata: got %h want 0", resp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    logic seen;
    // Stray ack while idle must not produce a response
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (resp_valid === 1'b1 || mem_req === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL idle ack: got activity 1 want 0"); end
    // New request while busy is dropped; the RAM side stays on the first one
    issue(1'b0, 3'b000, 32'h302, 32'h0);
    req_valid = 1'b1; req_addr = 32'h400; req_size = 3'b010;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_addr !== 32'h300 || mem_be !== 4'b0100) begin n_bad++; $display("FAIL busy hold: got %h %b want 00000300 0100", mem_addr, mem_be); end
    req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h00F1_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL busy resp: got v%b %h want v1 fffffff1", resp_valid, resp_rdata); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL busy after: got r%b q%b want r1 q0", req_ready, mem_req); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    issue(1'b0, 3'b010, 32'h500, 32'h0);
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid pre: got %b want 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid async: got q%b r%b want q0 r1", mem_req, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) mem_ack = 1'b1;
      if (resp_valid === 1'b1 || mem_req === 1'b1) seen = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid no resp: got activity 1 want 0"); end
    issue(1'b0, 3'b100, 32'h102, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h00AB_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 32'h0000_00AB) begin n_bad++; $display("FAIL rmid next: got v%b f%b %h want v1 f0 000000ab", resp_valid, resp_fault, resp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_illegal;
    test_misaligned;
    test_timeout;
    test_busy_ignore;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
